// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU classes and the decoder control word.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // ALU class produced by the main decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  // Hard-wired zero register; never a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       RegDst;
    logic       Jump;
    logic       Branch;
    logic       bne;
    logic       MemRead;
    logic       MemtoReg;
    logic       MemWrite;
    logic       ALUsrc;
    logic       RegWrite;
    logic [1:0] ALUop;
  } ctrl_t;

  // Bubble: no architectural side effects, ALU does a harmless add
  localparam ctrl_t CTRL_NOP = '{
    RegDst:   1'b0,
    Jump:     1'b0,
    Branch:   1'b0,
    bne:      1'b0,
    MemRead:  1'b0,
    MemtoReg: 1'b0,
    MemWrite: 1'b0,
    ALUsrc:   1'b0,
    RegWrite: 1'b0,
    ALUop:    ALU_ADD
  };

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_unit
  import mips_pkg::*;
(
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_ALUsrc,
  input  logic       id_MemWrite,
  input  logic       flush,
  output logic       stall
);

  logic w_rt_used;
  logic w_hz;

  // rt is a source when the ALU reads it (no immediate) or a store writes it to memory
  always_comb begin
    w_rt_used = !id_ALUsrc || id_MemWrite;
    w_hz      = ex_MemRead && (ex_rt != REG_ZERO) &&
                ((ex_rt == id_rs) || ((ex_rt == id_rt) && w_rt_used));
    stall     = w_hz && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion, flush and debug counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_RegDst,
  input  logic              id_Jump,
  input  logic              id_Branch,
  input  logic              id_bne,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUsrc,
  input  logic              id_RegWrite,
  input  logic [1:0]        id_ALUop,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  output logic              ex_RegDst,
  output logic              ex_Jump,
  output logic              ex_Branch,
  output logic              ex_bne,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUsrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUop,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [5:0]        ex_funct,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [5:0]        r_funct;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  ctrl_t             w_ctrl_id;
  ctrl_t             w_ctrl_d;
  logic              w_stall;
  logic [CNT_W-1:0]  w_stall_cnt_d;
  logic [CNT_W-1:0]  w_flush_cnt_d;

  hazard_unit u_hazard (
    .ex_MemRead  (r_ctrl.MemRead),
    .ex_rt       (r_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_ALUsrc   (id_ALUsrc),
    .id_MemWrite (id_MemWrite),
    .flush       (flush),
    .stall       (w_stall)
  );

  // Select the incoming control word or a bubble; stall already excludes flush
  always_comb begin
    w_ctrl_id = '{
      RegDst:   id_RegDst,
      Jump:     id_Jump,
      Branch:   id_Branch,
      bne:      id_bne,
      MemRead:  id_MemRead,
      MemtoReg: id_MemtoReg,
      MemWrite: id_MemWrite,
      ALUsrc:   id_ALUsrc,
      RegWrite: id_RegWrite,
      ALUop:    id_ALUop
    };
    w_ctrl_d = (flush || w_stall) ? CTRL_NOP : w_ctrl_id;
  end

  // Saturating event counters
  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    w_flush_cnt_d = r_flush_cnt;
    if (flush && (r_flush_cnt != CntMax)) begin
      w_flush_cnt_d = r_flush_cnt + CNT_W'(1);
    end
    if (w_stall && (r_stall_cnt != CntMax)) begin
      w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
    end
  end

  // Pipeline register; data fields load unconditionally since a bubble ignores them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl      <= CTRL_NOP;
      r_pc4       <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_funct     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ctrl      <= w_ctrl_d;
      r_pc4       <= id_pc4;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_rd        <= id_rd;
      r_funct     <= id_funct;
      r_stall_cnt <= w_stall_cnt_d;
      r_flush_cnt <= w_flush_cnt_d;
    end
  end

  assign ex_RegDst   = r_ctrl.RegDst;
  assign ex_Jump     = r_ctrl.Jump;
  assign ex_Branch   = r_ctrl.Branch;
  assign ex_bne      = r_ctrl.bne;
  assign ex_MemRead  = r_ctrl.MemRead;
  assign ex_MemtoReg = r_ctrl.MemtoReg;
  assign ex_MemWrite = r_ctrl.MemWrite;
  assign ex_ALUsrc   = r_ctrl.ALUsrc;
  assign ex_RegWrite = r_ctrl.RegWrite;
  assign ex_ALUop    = r_ctrl.ALUop;
  assign ex_pc4      = r_pc4;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm      = r_imm;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_funct    = r_funct;
  assign stall       = w_stall;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
